eco32_core_lsu_dcu_ways: RTL and testbench

- N-way set-associative tag/descriptor lookup for the ECO32 LSU data cache unit; generalises the single-way lookup to NUM_WAYS ways.
- Each way has its own per-thread page-descriptor table, written by the miss/fill logic.
- Two-stage pipelined lookup returns:
  - one-hot hit way and the translated address;
  - miss, locked and exception flags;
  - a replacement victim chosen per (tid, page) by round-robin over unlocked ways.
- Self-initialising: after reset an init sweep clears every entry before lookups are accepted.

---
 rtl/eco32_core_lsu_dcu_pkg.sv | 35 +++
 rtl/eco32_core_lsu_dcu_way_tab.sv | 25 ++
 rtl/eco32_core_lsu_dcu_ways.sv | 253 +++++++++++++++++++++++++
 tb/tb_eco32_core_lsu_dcu_ways.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/eco32_core_lsu_dcu_pkg.sv
// ECO32 LSU data cache unit: shared descriptor layout, widths and
// exception id encodings for the N-way tag/descriptor lookup.
package eco32_core_lsu_dcu_pkg;

    // Descriptor width; bits [38:36] are stored but carry no meaning here
    localparam int DESC_W       = 39;

    // Descriptor bit positions
    localparam int DESC_DBG     = 0;
    localparam int DESC_WR      = 1;
    localparam int DESC_RD      = 2;
    localparam int DESC_EXE     = 3;
    localparam int DESC_PID_LO  = 4;
    localparam int DESC_PID_HI  = 5;
    localparam int DESC_WRT     = 6;
    localparam int DESC_TAGBIT  = 7;
    localparam int DESC_LOCKED  = 8;
    localparam int DESC_AV      = 9;
    localparam int DESC_VALID   = 10;
    localparam int DESC_TAG_LO  = 11;
    localparam int DESC_TAG_HI  = 31;
    localparam int DESC_ASID_LO = 32;
    localparam int DESC_ASID_HI = 35;

    // Exception id encodings
    localparam logic [3:0] EXC_IDA_RD    = 4'b0100;
    localparam logic [3:0] EXC_IDP_AA    = 4'b0010;
    localparam logic [3:0] EXC_IDP_PID   = 4'b0001;
    localparam logic [3:0] EXC_IDT_TLB   = 4'b0001;
    localparam logic [3:0] EXC_IDT_MULTI = 4'b0010;

    // Lookup controller state
    typedef enum logic {ST_INIT, ST_RUN} dcu_state_e;

endpackage

// File: rtl/eco32_core_lsu_dcu_way_tab.sv
// One way's descriptor RAM, addressed by {tid, page}. Synchronous read,
// read-first: a same-cycle write to the read address returns the old entry.
module eco32_core_lsu_dcu_way_tab
    import eco32_core_lsu_dcu_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DESC_W-1:0] rdata
);

    logic [DESC_W-1:0] mem [0:(1<<AW)-1];

    // Write and registered read share one edge, so the read sees the old word
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/eco32_core_lsu_dcu_ways.sv
// ECO32 LSU DCU N-way set-associative descriptor lookup.
// Two-stage pipeline: a0 = table read + registered request, b1 = registered
// result. Self-clears all tables after reset before accepting lookups.
// Optional hit/miss counters: define ECO32_DCU_WAYS_PERF_EN.
module eco32_core_lsu_dcu_ways
    import eco32_core_lsu_dcu_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5,
    parameter int NUM_WAYS        = 4,
    parameter int WAY_IDX_W       = $clog2(NUM_WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_ready,
    input  logic                       i_stb,
    input  logic                       i_tid,
    input  logic [1:0]                 i_pid,
    input  logic [3:0]                 i_asid,
    input  logic [31:0]                i_v_addr,
    input  logic                       wr_pt_stb,
    input  logic                       wr_pt_tid,
    input  logic [WAY_IDX_W-1:0]       wr_pt_way,
    input  logic [PAGE_ADDR_WIDTH-1:0] wr_pt_page,
    input  logic [DESC_W-1:0]          wr_pt_descriptor,
    output logic                       o_stb,
    output logic                       o_tid,
    output logic [31:0]                o_v_addr,
    output logic                       o_hit,
    output logic [NUM_WAYS-1:0]        o_hit_way,
    output logic                       o_miss,
    output logic                       o_locked,
    output logic [WAY_IDX_W-1:0]       o_victim,
    output logic                       o_victim_wrt,
    output logic                       o_multi_hit,
    output logic                       o_exc,
    output logic [3:0]                 o_exc_ida,
    output logic [3:0]                 o_exc_idp,
    output logic [3:0]                 o_exc_idt
`ifdef ECO32_DCU_WAYS_PERF_EN
    ,
    output logic [31:0]                o_perf_hit,
    output logic [31:0]                o_perf_miss
`endif
);

    localparam int PAW   = PAGE_ADDR_WIDTH;
    localparam int AW    = PAW + 1;
    localparam int DEPTH = 1 << AW;

    dcu_state_e                         state;
    logic [AW-1:0]                      init_cnt;
    logic [NUM_WAYS-1:0]                tab_we;
    logic [AW-1:0]                      tab_waddr;
    logic [DESC_W-1:0]                  tab_wdata;
    logic [AW-1:0]                      tab_raddr;
    logic [NUM_WAYS-1:0][DESC_W-1:0]    rd_desc;
    logic [WAY_IDX_W-1:0]               rr_ptr [0:DEPTH-1];

    // a0 stage request registers
    logic [1:0]                         vld_pipe;
    logic                               a0_tid;
    logic [1:0]                         a0_pid;
    logic [3:0]                         a0_asid;
    logic [31:0]                        a0_vaddr;
    logic [WAY_IDX_W-1:0]               a0_rr;

    // b1 stage combinational result
    logic [NUM_WAYS-1:0]                hit_w, tlb_w, valid_w, locked_w;
    logic [WAY_IDX_W:0]                 hit_cnt;
    logic [WAY_IDX_W-1:0]               hit_idx, vic;
    logic [DESC_W-1:0]                  hit_desc;
    logic                               hit_one, hit_any, multi, tlb_any, all_locked, vic_found;
    logic                               ex_aa, ex_rd, ex_pid;

    // Init sweep: one {tid,page} entry per cycle across all ways, then RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            o_ready  <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + AW'(1);
            if (init_cnt == {AW{1'b1}}) begin
                state   <= ST_RUN;
                o_ready <= 1'b1;
            end
        end
    end

    // Table write source: sweep zeros during INIT, fill writes during RUN
    always_comb begin
        tab_we    = '0;
        tab_waddr = {wr_pt_tid, wr_pt_page};
        tab_wdata = wr_pt_descriptor;
        if (state == ST_INIT) begin
            tab_we    = '1;
            tab_waddr = init_cnt;
            tab_wdata = '0;
        end else if (wr_pt_stb) begin
            tab_we[wr_pt_way] = 1'b1;
        end
    end

    assign tab_raddr = {i_tid, i_v_addr[PAW+5:6]};

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        eco32_core_lsu_dcu_way_tab #(.AW(AW)) u_tab (
            .clk   (clk),
            .we    (tab_we[w]),
            .waddr (tab_waddr),
            .wdata (tab_wdata),
            .raddr (tab_raddr),
            .rdata (rd_desc[w])
        );
        logic unused_bits;
        assign unused_bits = ^{rd_desc[w][DESC_W-1:36], rd_desc[w][DESC_TAGBIT],
                               rd_desc[w][DESC_EXE], rd_desc[w][DESC_WR], rd_desc[w][DESC_DBG]};
    end

    // Round-robin pointer per {tid,page}; advances past the way just filled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                rr_ptr[i] <= '0;
        end else if (state == ST_RUN && wr_pt_stb && wr_pt_descriptor[DESC_VALID]) begin
            rr_ptr[{wr_pt_tid, wr_pt_page}] <= wr_pt_way + WAY_IDX_W'(1);
        end
    end

    // a0: capture accepted request alongside the synchronous table read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            a0_tid   <= 1'b0;
            a0_pid   <= '0;
            a0_asid  <= '0;
            a0_vaddr <= '0;
            a0_rr    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], i_stb & o_ready};
            a0_tid   <= i_tid;
            a0_pid   <= i_pid;
            a0_asid  <= i_asid;
            a0_vaddr <= i_v_addr;
            a0_rr    <= rr_ptr[{i_tid, i_v_addr[PAW+5:6]}];
        end
    end

    // b1: per-way match, hit/exception classification and victim choice
    always_comb begin
        hit_w     = '0;
        tlb_w     = '0;
        valid_w   = '0;
        locked_w  = '0;
        hit_cnt   = '0;
        hit_idx   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            valid_w[w]  = rd_desc[w][DESC_VALID];
            locked_w[w] = rd_desc[w][DESC_LOCKED];
            hit_w[w] = rd_desc[w][DESC_VALID] & rd_desc[w][DESC_AV] & !rd_desc[w][DESC_LOCKED]
                     & (rd_desc[w][DESC_ASID_HI:DESC_ASID_LO] == a0_asid)
                     & (rd_desc[w][DESC_TAG_HI:PAW+6] == a0_vaddr[31:PAW+6]);
            tlb_w[w] = rd_desc[w][DESC_VALID] & !rd_desc[w][DESC_AV]
                     & (rd_desc[w][DESC_TAG_HI:PAW+6] == a0_vaddr[31:PAW+6]);
            hit_cnt = hit_cnt + (WAY_IDX_W+1)'(hit_w[w]);
            if (hit_w[w])
                hit_idx = WAY_IDX_W'(w);
        end
        hit_any    = |hit_w;
        hit_one    = (hit_cnt == (WAY_IDX_W+1)'(1));
        multi      = (hit_cnt > (WAY_IDX_W+1)'(1));
        tlb_any    = |tlb_w;
        all_locked = &locked_w;
        hit_desc   = rd_desc[hit_idx];
        ex_aa      = |a0_vaddr[1:0];
        ex_rd      = !hit_desc[DESC_RD];
        ex_pid     = hit_desc[DESC_PID_HI:DESC_PID_LO] < a0_pid;

        // Prefer an empty unlocked way, else rotate from rr_ptr over unlocked ways
        vic       = a0_rr;
        vic_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!vic_found && !valid_w[w] && !locked_w[w]) begin
                vic       = WAY_IDX_W'(w);
                vic_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (!vic_found && !locked_w[a0_rr + WAY_IDX_W'(k)]) begin
                vic       = a0_rr + WAY_IDX_W'(k);
                vic_found = 1'b1;
            end
        end
    end

    // b1 result register; every field is forced to 0 without a valid lookup.
    // o_hit_way carries the raw match vector so a multi-hit shows its ways.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stb        <= 1'b0;
            o_tid        <= 1'b0;
            o_v_addr     <= '0;
            o_hit        <= 1'b0;
            o_hit_way    <= '0;
            o_miss       <= 1'b0;
            o_locked     <= 1'b0;
            o_victim     <= '0;
            o_victim_wrt <= 1'b0;
            o_multi_hit  <= 1'b0;
            o_exc        <= 1'b0;
            o_exc_ida    <= '0;
            o_exc_idp    <= '0;
            o_exc_idt    <= '0;
        end else begin
            o_stb        <= vld_pipe[0];
            o_tid        <= vld_pipe[0] & a0_tid;
            o_v_addr     <= !vld_pipe[0] ? '0 :
                            hit_one ? {hit_desc[DESC_TAG_HI:DESC_TAG_LO], a0_vaddr[10:0]} : a0_vaddr;
            o_hit        <= vld_pipe[0] & hit_one;
            o_hit_way    <= vld_pipe[0] ? hit_w : '0;
            o_miss       <= vld_pipe[0] & !hit_any & !all_locked;
            o_locked     <= vld_pipe[0] & !hit_any & all_locked;
            o_victim     <= vld_pipe[0] ? vic : '0;
            o_victim_wrt <= vld_pipe[0] & rd_desc[vic][DESC_WRT];
            o_multi_hit  <= vld_pipe[0] & multi;
            o_exc        <= vld_pipe[0] & (multi | (hit_one & (ex_aa | ex_rd | ex_pid))
                                                 | (!hit_any & tlb_any));
            o_exc_ida    <= (vld_pipe[0] & hit_one & ex_rd) ? EXC_IDA_RD : 4'b0;
            o_exc_idp    <= (vld_pipe[0] & hit_one) ?
                            ((ex_aa ? EXC_IDP_AA : 4'b0) | (ex_pid ? EXC_IDP_PID : 4'b0)) : 4'b0;
            o_exc_idt    <= !vld_pipe[0] ? 4'b0 :
                            multi ? EXC_IDT_MULTI : (tlb_any ? EXC_IDT_TLB : 4'b0);
        end
    end

`ifdef ECO32_DCU_WAYS_PERF_EN
    // Saturating hit/miss event counters on the registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_perf_hit  <= '0;
            o_perf_miss <= '0;
        end else begin
            if (o_stb && o_hit && o_perf_hit != 32'hFFFF_FFFF)
                o_perf_hit <= o_perf_hit + 32'd1;
            if (o_stb && o_miss && o_perf_miss != 32'hFFFF_FFFF)
                o_perf_miss <= o_perf_miss + 32'd1;
        end
    end
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_eco32_core_lsu_dcu_ways.sv
// Directed bench for eco32_core_lsu_dcu_ways (default parameters).
module tb_eco32_core_lsu_dcu_ways;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        o_ready;
    logic        i_stb = 1'b0;
    logic        i_tid = 1'b0;
    logic [1:0]  i_pid = '0;
    logic [3:0]  i_asid = '0;
    logic [31:0] i_v_addr = '0;
    logic        wr_pt_stb = 1'b0;
    logic        wr_pt_tid = 1'b0;
    logic [1:0]  wr_pt_way = '0;
    logic [4:0]  wr_pt_page = '0;
    logic [38:0] wr_pt_descriptor = '0;
    logic        o_stb, o_tid, o_hit, o_miss, o_locked, o_victim_wrt, o_multi_hit, o_exc;
    logic [31:0] o_v_addr;
    logic [3:0]  o_hit_way;
    logic [1:0]  o_victim;
    logic [3:0]  o_exc_ida, o_exc_idp, o_exc_idt;
`ifdef ECO32_DCU_WAYS_PERF_EN
    logic [31:0] o_perf_hit, o_perf_miss;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    eco32_core_lsu_dcu_ways dut (
        .clk(clk), .rst(rst), .o_ready(o_ready),
        .i_stb(i_stb), .i_tid(i_tid), .i_pid(i_pid), .i_asid(i_asid), .i_v_addr(i_v_addr),
        .wr_pt_stb(wr_pt_stb), .wr_pt_tid(wr_pt_tid), .wr_pt_way(wr_pt_way),
        .wr_pt_page(wr_pt_page), .wr_pt_descriptor(wr_pt_descriptor),
        .o_stb(o_stb), .o_tid(o_tid), .o_v_addr(o_v_addr), .o_hit(o_hit), .o_hit_way(o_hit_way),
        .o_miss(o_miss), .o_locked(o_locked), .o_victim(o_victim), .o_victim_wrt(o_victim_wrt),
        .o_multi_hit(o_multi_hit), .o_exc(o_exc),
        .o_exc_ida(o_exc_ida), .o_exc_idp(o_exc_idp), .o_exc_idt(o_exc_idt)
`ifdef ECO32_DCU_WAYS_PERF_EN
        , .o_perf_hit(o_perf_hit), .o_perf_miss(o_perf_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] mk(input logic [3:0] asid, input logic [20:0] tag,
                                       input logic v, input logic av, input logic lk,
                                       input logic wrt, input logic [1:0] pid, input logic rd);
        logic [38:0] d;
        d = '0;
        d[35:32] = asid; d[31:11] = tag; d[10] = v; d[9] = av; d[8] = lk;
        d[6] = wrt; d[5:4] = pid; d[2] = rd;
        return d;
    endfunction

    task automatic wr(input logic tid, input logic [1:0] way, input logic [4:0] page,
                      input logic [38:0] d);
        wr_pt_stb = 1'b1; wr_pt_tid = tid; wr_pt_way = way; wr_pt_page = page; wr_pt_descriptor = d;
        @(posedge clk); #1;
        wr_pt_stb = 1'b0;
    endtask

    // Issue one lookup and leave outputs sampled at T+2
    task automatic lk(input logic tid, input logic [1:0] pid, input logic [3:0] asid,
                      input logic [31:0] addr);
        i_stb = 1'b1; i_tid = tid; i_pid = pid; i_asid = asid; i_v_addr = addr;
        @(posedge clk); #1;
        i_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!o_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_stb", o_stb, 0);
        chk("rst_victim", o_victim, 0);
        rst = 1'b1;
        wait_ready(n);
        chk("init_cycles", n, 64);

        // Empty tables: plain miss, victim way 0
        lk(0, 0, 0, 32'h0000_1040);
        chk("t1_stb", o_stb, 1);
        chk("t1_miss", o_miss, 1);
        chk("t1_victim", o_victim, 0);
        chk("t1_hit_way", o_hit_way, 0);
        chk("t1_vaddr", o_v_addr, 32'h0000_1040);

        // Single hit in way 2
        wr(0, 2, 1, mk(4'd3, 21'h0ABCDE, 1, 1, 0, 0, 2'd3, 1));
        lk(0, 0, 3, 32'h55E6_F044);
        chk("t2_hit", o_hit, 1);
        chk("t2_hit_way", o_hit_way, 4'b0100);
        chk("t2_tag", o_v_addr[31:11], 21'h0ABCDE);
        chk("t2_vaddr", o_v_addr, 32'h55E6_F044);
        chk("t2_miss", o_miss, 0);
        chk("t2_exc", o_exc, 0);
        lk(0, 0, 4, 32'h55E6_F044);
        chk("t2_asid_miss", {o_hit, o_miss, o_exc}, 3'b010);

        // Same entry in ways 1 and 2 -> multi-hit
        wr(0, 1, 1, mk(4'd3, 21'h0ABCDE, 1, 1, 0, 0, 2'd3, 1));
        lk(0, 0, 3, 32'h55E6_F044);
        chk("t3_multi", o_multi_hit, 1);
        chk("t3_hit", o_hit, 0);
        chk("t3_exc", o_exc, 1);
        chk("t3_idt", o_exc_idt, 4'b0010);
        chk("t3_miss", o_miss, 0);

        // Round-robin victim: fill ways 3,0,1,2 (way 3 dirty) -> rr=3
        wr(1, 3, 2, mk(4'd5, 21'h00111, 1, 1, 0, 1, 2'd0, 1));
        wr(1, 0, 2, mk(4'd5, 21'h00111, 1, 1, 0, 0, 2'd0, 1));
        wr(1, 1, 2, mk(4'd5, 21'h00111, 1, 1, 0, 0, 2'd0, 1));
        wr(1, 2, 2, mk(4'd5, 21'h00111, 1, 1, 0, 0, 2'd0, 1));
        lk(1, 0, 5, 32'h0011_1080);
        chk("t4_miss", o_miss, 1);
        chk("t4_victim", o_victim, 3);
        chk("t4_victim_wrt", o_victim_wrt, 1);
        chk("t4_tid", o_tid, 1);
        // Lock way 3 (rr -> 0)
        wr(1, 3, 2, mk(4'd5, 21'h00111, 1, 1, 1, 1, 2'd0, 1));
        lk(1, 0, 5, 32'h0011_1080);
        chk("t4_lock3_victim", o_victim, 0);
        chk("t4_lock3_wrt", o_victim_wrt, 0);
        // Lock ways 0,1,2 in order (rr -> 3)
        wr(1, 0, 2, mk(4'd5, 21'h00111, 1, 1, 1, 0, 2'd0, 1));
        wr(1, 1, 2, mk(4'd5, 21'h00111, 1, 1, 1, 0, 2'd0, 1));
        wr(1, 2, 2, mk(4'd5, 21'h00111, 1, 1, 1, 0, 2'd0, 1));
        lk(1, 0, 5, 32'h0011_1080);
        chk("t4_all_locked", o_locked, 1);
        chk("t4_all_miss", o_miss, 0);
        chk("t4_all_victim", o_victim, 3);

        // TLB-class entry (valid, !av) in way 0
        wr(1, 0, 3, mk(4'd5, 21'h00333, 1, 0, 0, 0, 2'd0, 1));
        lk(1, 0, 5, 32'h0019_98C0);
        chk("t5_tlb_exc", o_exc, 1);
        chk("t5_tlb_idt", o_exc_idt, 4'b0001);
        chk("t5_tlb_victim", o_victim, 1);

        // Hitting way with rd=0, misaligned address
        wr(0, 0, 4, mk(4'd3, 21'h00055, 1, 1, 0, 0, 2'd1, 0));
        lk(0, 0, 3, 32'h0002_A902);
        chk("t6_hit", o_hit, 1);
        chk("t6_exc", o_exc, 1);
        chk("t6_ida", o_exc_ida, 4'b0100);
        chk("t6_idp", o_exc_idp, 4'b0010);
        lk(0, 2, 3, 32'h0002_A902);
        chk("t6_idp_pid", o_exc_idp, 4'b0011);

        // Write and lookup same tid/page in one cycle: lookup sees old entry
        wr_pt_stb = 1'b1; wr_pt_tid = 0; wr_pt_way = 0; wr_pt_page = 5'd5;
        wr_pt_descriptor = mk(4'd2, 21'h00777, 1, 1, 0, 0, 2'd0, 1);
        i_stb = 1'b1; i_tid = 0; i_pid = 0; i_asid = 4'd2; i_v_addr = 32'h003B_B940;
        @(posedge clk); #1;
        wr_pt_stb = 1'b0; i_stb = 1'b0;
        @(posedge clk); #1;
        chk("t7_collide_hit", o_hit, 0);
        lk(0, 0, 2, 32'h003B_B940);
        chk("t7_after_hit", o_hit, 1);

        // Reset two cycles into a back-to-back lookup stream
        i_stb = 1'b1; i_tid = 0; i_pid = 0; i_asid = 4'd3; i_v_addr = 32'h55E6_F044;
        repeat (2) @(posedge clk);
        #1;
        chk("t8_stream_stb", o_stb, 1);
        rst = 1'b0;
        #1;
        chk("t8_rst_stb", o_stb, 0);
        chk("t8_rst_ready", o_ready, 0);
        chk("t8_rst_multi", o_multi_hit, 0);
        i_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        // A fill during the sweep must be dropped
        repeat (20) @(posedge clk);
        #1;
        wr(0, 0, 6, mk(4'd1, 21'h00999, 1, 1, 0, 0, 2'd0, 1));
        wait_ready(n);
        chk("t8_reinit_cycles", n, 64 - 21);
        lk(0, 0, 3, 32'h55E6_F044);
        chk("t8_cleared_hit", o_hit, 0);
        chk("t8_cleared_miss", o_miss, 1);
        lk(0, 0, 1, 32'h004C_C980);
        chk("t8_init_wr_ignored", o_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
